pixel_reg_loader: RTL and testbench

//  Upstream write sequencer for the 9-bit register bank stage.

---
 rtl/pixel_reg_loader.sv | 94 +++++++++
 tb/tb_pixel_reg_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_reg_loader.sv
// Write sequencer for the 9-bit register bank: turns each accepted pixel sample into one
// addressed write strobe, with sequential addressing per frame and an optional settling gap.
module pixel_reg_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 9,
  parameter int unsigned NUM_WORDS = 256,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned WR_GAP    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_data,
  output logic              reg_sig,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned GAP_W = 4;
  localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'((WR_GAP == 0) ? 0 : WR_GAP - 1);

  typedef enum logic [1:0] {IDLE, LOAD, GAP, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] idx;
  logic [GAP_W-1:0] gap_cnt;
  logic             accept;

  // Ready follows abort within the cycle so a handshake can never coincide with an abort.
  assign in_ready = (state == LOAD) && !abort && !rst;
  assign busy     = (state != IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      gap_cnt    <= '0;
      reg_addr   <= '0;
      reg_data   <= '0;
      reg_sig    <= 1'b0;
      frame_done <= 1'b0;
      word_count <= '0;
    end else begin
      reg_sig    <= 1'b0;
      frame_done <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state      <= LOAD;
              idx        <= '0;
              word_count <= '0;
            end
          end
          LOAD: begin
            if (accept) begin
              reg_sig    <= 1'b1;
              reg_addr   <= BASE + idx[ADDR_W-1:0];
              reg_data   <= in_data;
              word_count <= word_count + 1'b1;
              idx        <= idx + 1'b1;
              if (idx == LAST_IDX) begin
                state      <= DONE;
                frame_done <= 1'b1;
              end else if (WR_GAP > 0) begin
                state   <= GAP;
                gap_cnt <= GAP_RELOAD;
              end
            end
          end
          GAP: begin
            if (gap_cnt == '0) state <= LOAD;
            else               gap_cnt <= gap_cnt - 1'b1;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_reg_loader.sv
// Bench for pixel_reg_loader: four differently configured instances share one stimulus stream
// and are each compared every cycle against a frame-level behavioural model.
module tb_pixel_reg_loader;

  localparam int unsigned N_DUT = 4;

  function automatic int unsigned nw_of(input int unsigned i);
    return (i == 3) ? 1 : 4;
  endfunction
  function automatic int unsigned gap_of(input int unsigned i);
    case (i)
      1: return 2;
      3: return 3;
      default: return 0;
    endcase
  endfunction
  function automatic int unsigned base_of(input int unsigned i);
    case (i)
      2: return 32'hFE;
      3: return 32'h80;
      default: return 0;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst, start, abort, in_valid;
  logic [8:0] in_data;

  logic [N_DUT-1:0] rdy_a, busy_a, sig_a, fd_a;
  logic [7:0] addr_a [N_DUT];
  logic [8:0] data_a [N_DUT];
  logic [8:0] wc_a   [N_DUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    pixel_reg_loader #(
      .ADDR_W(8), .DATA_W(9), .NUM_WORDS(nw_of(g)), .BASE_ADDR(base_of(g)), .WR_GAP(gap_of(g))
    ) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a[g]),
      .reg_addr(addr_a[g]), .reg_data(data_a[g]), .reg_sig(sig_a[g]),
      .busy(busy_a[g]), .frame_done(fd_a[g]), .word_count(wc_a[g])
    );
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Frame-level reference: accepts counted per frame, readiness from cycles since last accept.
  bit     m_act  [N_DUT];
  bit     m_done [N_DUT];
  bit     m_sig  [N_DUT];
  bit     m_fd   [N_DUT];
  int     m_n    [N_DUT];
  int     m_wc   [N_DUT];
  int     m_addr [N_DUT];
  int     m_data [N_DUT];
  longint m_last [N_DUT];
  longint cyc = 0;

  bit log_en = 1'b0;
  int q0_data[$];
  int q2_addr[$];

  initial begin
    for (int i = 0; i < N_DUT; i++) begin
      m_act[i] = 0; m_done[i] = 0; m_sig[i] = 0; m_fd[i] = 0;
      m_n[i] = 0; m_wc[i] = 0; m_addr[i] = 0; m_data[i] = 0; m_last[i] = -1000;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N_DUT; i++) begin
      bit e_rdy, e_busy, hs;
      e_rdy  = !rst && m_act[i] && !abort && ((cyc - m_last[i]) > longint'(gap_of(i)));
      e_busy = !rst && (m_act[i] || m_done[i]);
      check($sformatf("u%0d.in_ready", i),   32'(rdy_a[i]),  32'(e_rdy));
      check($sformatf("u%0d.busy", i),       32'(busy_a[i]), 32'(e_busy));
      check($sformatf("u%0d.reg_sig", i),    32'(sig_a[i]),  32'(m_sig[i]));
      check($sformatf("u%0d.frame_done", i), 32'(fd_a[i]),   32'(m_fd[i]));
      check($sformatf("u%0d.word_count", i), 32'(wc_a[i]),   32'(m_wc[i]));
      check($sformatf("u%0d.reg_addr", i),   32'(addr_a[i]), 32'(m_addr[i]));
      check($sformatf("u%0d.reg_data", i),   32'(data_a[i]), 32'(m_data[i]));
      if (log_en && i == 0 && sig_a[0]) q0_data.push_back(int'(data_a[0]));
      if (log_en && i == 2 && sig_a[2]) q2_addr.push_back(int'(addr_a[2]));

      hs = in_valid && e_rdy;
      if (rst) begin
        m_act[i] = 0; m_done[i] = 0; m_sig[i] = 0; m_fd[i] = 0;
        m_n[i] = 0; m_wc[i] = 0; m_addr[i] = 0; m_data[i] = 0; m_last[i] = -1000;
      end else begin
        m_sig[i] = 0;
        m_fd[i]  = 0;
        if (abort) begin
          m_act[i] = 0; m_done[i] = 0;
        end else if (!(m_act[i] || m_done[i]) && start) begin
          m_act[i] = 1; m_n[i] = 0; m_wc[i] = 0; m_last[i] = -1000;
        end else if (m_done[i]) begin
          m_done[i] = 0;
        end else if (hs) begin
          m_sig[i]  = 1;
          m_addr[i] = (int'(base_of(i)) + m_n[i]) % 256;
          m_data[i] = int'(in_data);
          m_n[i]++;
          m_wc[i]   = m_n[i];
          m_last[i] = cyc;
          if (m_n[i] == int'(nw_of(i))) begin
            m_act[i] = 0; m_done[i] = 1; m_fd[i] = 1;
          end
        end
      end
    end
    cyc++;
  end

  task automatic step(input bit st, input bit ab, input bit v, input logic [8:0] d);
    @(posedge clk);
    #1;
    start = st; abort = ab; in_valid = v; in_data = d;
  endtask

  initial begin
    logic [8:0] tbl [4];
    bit pat [7];
    tbl = '{9'h1FF, 9'h000, 9'h155, 9'h0AA};
    pat = '{1, 0, 0, 1, 1, 0, 1};

    // Reset held with valid and start asserted.
    rst = 1'b1; start = 1'b1; abort = 1'b0; in_valid = 1'b1; in_data = 9'h123;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;

    // Back-to-back frame.
    step(0, 0, 0, 9'h0);
    step(1, 0, 0, 9'h0);
    log_en = 1'b1;
    for (int k = 0; k < 4; k++) step(0, 0, 1, tbl[k]);
    for (int k = 0; k < 16; k++) step(0, 0, 1, 9'($urandom));
    step(0, 0, 0, 9'h0);
    step(0, 0, 0, 9'h0);
    log_en = 1'b0;
    check("t2.strobes", 32'(q0_data.size()), 32'd4);
    for (int k = 0; k < 4 && k < q0_data.size(); k++)
      check($sformatf("t2.data%0d", k), 32'(q0_data[k]), 32'(tbl[k]));
    check("t5.strobes", 32'(q2_addr.size()), 32'd4);
    for (int k = 0; k < 4 && k < q2_addr.size(); k++)
      check($sformatf("t5.addr%0d", k), 32'(q2_addr[k]), 32'((32'hFE + k) % 256));
    check("t2.word_count", 32'(wc_a[0]), 32'd4);
    check("t2.busy", 32'(busy_a[0]), 32'd0);

    // Bubbled valid pattern.
    step(1, 0, 0, 9'h0);
    for (int k = 0; k < 7; k++) step(0, 0, pat[k], 9'($urandom));
    repeat (6) step(0, 0, 0, 9'h0);

    // Abort during the second strobe, then restart.
    step(1, 0, 0, 9'h0);
    step(0, 0, 1, 9'h011);
    step(0, 0, 1, 9'h022);
    step(0, 1, 1, 9'h033);
    step(0, 0, 0, 9'h0);
    check("t6.word_count", 32'(wc_a[0]), 32'd2);
    check("t6.busy", 32'(busy_a[0]), 32'd0);
    step(1, 0, 0, 9'h0);
    step(0, 0, 0, 9'h0);
    check("t6.restart_wc", 32'(wc_a[0]), 32'd0);
    check("t6.restart_busy", 32'(busy_a[0]), 32'd1);
    step(0, 0, 1, 9'h044);
    step(0, 0, 0, 9'h0);
    check("t6.restart_sig", 32'(sig_a[0]), 32'd1);
    check("t6.restart_addr", 32'(addr_a[0]), 32'd0);
    repeat (8) step(0, 0, 0, 9'h0);

    // Randomized traffic, including occasional aborts and mid-frame resets.
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      rst      = ($urandom_range(499) == 0);
      start    = ($urandom_range(7) == 0);
      abort    = ($urandom_range(63) == 0);
      in_valid = ($urandom_range(1) == 1);
      in_data  = 9'($urandom);
    end
    step(0, 0, 0, 9'h0);
    rst = 1'b0;
    repeat (4) step(0, 0, 0, 9'h0);

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
